// File: rtl/spi_pwm_config_ctrl_if.sv
// Pin-side SPI signals and the PWM configuration outputs.
// The host or pin driver uses master; the config controller uses slave.
interface spi_pwm_config_ctrl_if;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       wr_strobe;
    logic       frame_err;

    modport master (
        output sclk, copi, ncs,
        input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0,
               en_reg_pwm_15_8, pwm_duty_cycle, wr_strobe, frame_err
    );

    modport slave (
        input  sclk, copi, ncs,
        output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0,
               en_reg_pwm_15_8, pwm_duty_cycle, wr_strobe, frame_err
    );
endinterface

// File: rtl/spi_pwm_config_ctrl.sv
// SPI mode-0 write-only target: synchronises the SPI pins, deserialises
// 16-bit frames and commits them into five 8-bit PWM configuration registers.
module spi_pwm_config_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    spi_pwm_config_ctrl_if.slave   bus
);

    localparam int NUM_REGS = 5;
    localparam int SETTLE   = SYNC_STAGES + 1;
    localparam int SETTLE_W = $clog2(SETTLE + 1);
    localparam logic [6:0] MAX_ADDR_L = 7'(MAX_ADDR);
    localparam logic [6:0] NUM_REGS_L = 7'(NUM_REGS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_reg;
    logic [SYNC_STAGES-1:0] copi_sync_reg;
    logic [SYNC_STAGES-1:0] ncs_sync_reg;
    logic                   sclk_dly_reg;
    logic                   ncs_dly_reg;
    logic [SETTLE_W-1:0]    settle_reg;
    logic                   armed_reg;

    state_t      state_reg;
    logic [15:0] shift_reg;
    logic [4:0]  bit_cnt_reg;
    logic [7:0]  cfg_reg [NUM_REGS];
    logic        wr_strobe_reg;
    logic        frame_err_reg;

    logic sclk_s, copi_s, ncs_s;
    logic sclk_rise, ncs_fall, ncs_rise;
    logic settled;
    logic [6:0] addr;
    logic       addr_ok;

    assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
    assign copi_s    = copi_sync_reg[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync_reg[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_dly_reg;
    assign ncs_fall  = ~ncs_s & ncs_dly_reg;
    assign ncs_rise  = ncs_s & ~ncs_dly_reg;
    assign settled   = (settle_reg == SETTLE_W'(SETTLE));
    assign addr      = shift_reg[14:8];
    assign addr_ok   = (addr <= MAX_ADDR_L) && (addr < NUM_REGS_L);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_reg <= '0;
            copi_sync_reg <= '0;
            ncs_sync_reg  <= '1;
            sclk_dly_reg  <= 1'b0;
            ncs_dly_reg   <= 1'b1;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], bus.sclk};
            copi_sync_reg <= {copi_sync_reg[SYNC_STAGES-2:0], bus.copi};
            ncs_sync_reg  <= {ncs_sync_reg[SYNC_STAGES-2:0], bus.ncs};
            sclk_dly_reg  <= sclk_s;
            ncs_dly_reg   <= ncs_s;
        end
    end

    // The synchroniser resets to ncs=1, so a pin already low at reset release
    // would look like a falling edge. Frames are only accepted once the
    // pipeline has flushed and ncs has genuinely been seen high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_reg <= '0;
            armed_reg  <= 1'b0;
        end else if (!settled) begin
            settle_reg <= settle_reg + 1'b1;
        end else if (ncs_s) begin
            armed_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            shift_reg     <= '0;
            bit_cnt_reg   <= '0;
            wr_strobe_reg <= 1'b0;
            frame_err_reg <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                cfg_reg[i] <= '0;
            end
        end else begin
            wr_strobe_reg <= 1'b0;
            frame_err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    shift_reg   <= '0;
                    bit_cnt_reg <= '0;
                    if (armed_reg && ncs_fall) begin
                        state_reg <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // ncs_rise has priority over a coincident sclk_rise
                    if (ncs_rise) begin
                        state_reg <= ST_COMMIT;
                    end else if (sclk_rise) begin
                        shift_reg <= {shift_reg[14:0], copi_s};
                        if (bit_cnt_reg != 5'd17) begin
                            bit_cnt_reg <= bit_cnt_reg + 5'd1;
                        end
                    end
                end
                ST_COMMIT: begin
                    if (bit_cnt_reg != 5'd16) begin
                        frame_err_reg <= 1'b1;
                    end else if (shift_reg[15] && addr_ok) begin
                        cfg_reg[addr[2:0]] <= shift_reg[7:0];
                        wr_strobe_reg      <= 1'b1;
                    end
                    shift_reg   <= '0;
                    bit_cnt_reg <= '0;
                    state_reg   <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.en_reg_out_7_0  = cfg_reg[0];
    assign bus.en_reg_out_15_8 = cfg_reg[1];
    assign bus.en_reg_pwm_7_0  = cfg_reg[2];
    assign bus.en_reg_pwm_15_8 = cfg_reg[3];
    assign bus.pwm_duty_cycle  = cfg_reg[4];
    assign bus.wr_strobe       = wr_strobe_reg;
    assign bus.frame_err       = frame_err_reg;

endmodule

// File: tb/tb_spi_pwm_config_ctrl.sv
// Directed bench for spi_pwm_config_ctrl: SPI frames at sclk = clk/8 with
// hand-computed register, strobe and error expectations.
module tb_spi_pwm_config_ctrl;

    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;
    int   strobe_cnt  = 0;
    int   err_cnt     = 0;
    int   strobe_base;
    int   err_base;

    spi_pwm_config_ctrl_if bus ();

    spi_pwm_config_ctrl #(
        .SYNC_STAGES(SYNC),
        .MAX_ADDR   (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.wr_strobe === 1'b1) strobe_cnt++;
        if (bus.frame_err === 1'b1) err_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("vector %0d %s observed=0x%0h expected=0x%0h", vectors, tag, obs, exp);
    endtask

    task automatic check_regs(input string tag, input logic [7:0] r0, input logic [7:0] r1,
                              input logic [7:0] r2, input logic [7:0] r3, input logic [7:0] r4);
        check({tag, ".out_7_0"},  {24'd0, bus.en_reg_out_7_0},  {24'd0, r0});
        check({tag, ".out_15_8"}, {24'd0, bus.en_reg_out_15_8}, {24'd0, r1});
        check({tag, ".pwm_7_0"},  {24'd0, bus.en_reg_pwm_7_0},  {24'd0, r2});
        check({tag, ".pwm_15_8"}, {24'd0, bus.en_reg_pwm_15_8}, {24'd0, r3});
        check({tag, ".duty"},     {24'd0, bus.pwm_duty_cycle},  {24'd0, r4});
    endtask

    task automatic spi_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus.copi = v[i];
            wait_clk(4);
            bus.sclk = 1'b1;
            wait_clk(4);
            bus.sclk = 1'b0;
        end
    endtask

    // Leaves ncs just raised at a falling clk edge; caller decides the gap.
    task automatic spi_frame(input logic [31:0] v, input int n);
        bus.ncs = 1'b0;
        wait_clk(4);
        spi_bits(v, n);
        wait_clk(4);
        bus.ncs = 1'b1;
    endtask

    initial begin
        bus.sclk = 1'b0;
        bus.copi = 1'b0;
        bus.ncs  = 1'b1;

        // Reset then idle
        wait_clk(1);
        rst = 1'b1;
        wait_clk(3);
        check_regs("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        check("reset.wr_strobe", {31'd0, bus.wr_strobe}, 32'd0);
        check("reset.frame_err", {31'd0, bus.frame_err}, 32'd0);
        rst = 1'b0;
        wait_clk(10);

        // Valid write with exact commit latency
        strobe_base = strobe_cnt;
        spi_frame(32'h8480, 16);
        wait_clk(SYNC + 1);
        check("lat.duty_before", {24'd0, bus.pwm_duty_cycle}, 32'h00);
        check("lat.strobe_before", {31'd0, bus.wr_strobe}, 32'd0);
        wait_clk(1);
        check("lat.duty_at", {24'd0, bus.pwm_duty_cycle}, 32'h80);
        check("lat.strobe_at", {31'd0, bus.wr_strobe}, 32'd1);
        wait_clk(1);
        check("lat.strobe_after", {31'd0, bus.wr_strobe}, 32'd0);
        wait_clk(6);
        check_regs("write1", 8'h00, 8'h00, 8'h00, 8'h00, 8'h80);
        check("write1.strobes", strobe_cnt - strobe_base, 32'd1);

        // All addresses back-to-back, ncs high for two clks between frames
        strobe_base = strobe_cnt;
        err_base    = err_cnt;
        spi_frame(32'h80F0, 16); wait_clk(2);
        spi_frame(32'h81CC, 16); wait_clk(2);
        spi_frame(32'h82FF, 16); wait_clk(2);
        spi_frame(32'h8301, 16); wait_clk(2);
        spi_frame(32'h8440, 16); wait_clk(10);
        check_regs("b2b", 8'hF0, 8'hCC, 8'hFF, 8'h01, 8'h40);
        check("b2b.strobes", strobe_cnt - strobe_base, 32'd5);
        check("b2b.errors", err_cnt - err_base, 32'd0);

        // Read frame and out-of-range write are silently dropped
        strobe_base = strobe_cnt;
        err_base    = err_cnt;
        spi_frame(32'h0055, 16); wait_clk(10);
        spi_frame(32'h8555, 16); wait_clk(10);
        check_regs("drop", 8'hF0, 8'hCC, 8'hFF, 8'h01, 8'h40);
        check("drop.strobes", strobe_cnt - strobe_base, 32'd0);
        check("drop.errors", err_cnt - err_base, 32'd0);

        // Short frame: 15 MSBs of 0x8011
        err_base = err_cnt;
        spi_frame(32'h4008, 15); wait_clk(10);
        check_regs("short", 8'hF0, 8'hCC, 8'hFF, 8'h01, 8'h40);
        check("short.errors", err_cnt - err_base, 32'd1);

        // Long frame: 0x8033 followed by one extra bit
        err_base    = err_cnt;
        strobe_base = strobe_cnt;
        spi_frame(32'h10067, 17); wait_clk(10);
        check_regs("long", 8'hF0, 8'hCC, 8'hFF, 8'h01, 8'h40);
        check("long.errors", err_cnt - err_base, 32'd1);
        check("long.strobes", strobe_cnt - strobe_base, 32'd0);

        // Reset mid-frame, released with ncs still low
        bus.ncs = 1'b0;
        wait_clk(4);
        spi_bits(32'h80, 8);
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        strobe_base = strobe_cnt;
        err_base    = err_cnt;
        spi_bits(32'hAA, 8);
        wait_clk(4);
        bus.ncs = 1'b1;
        wait_clk(10);
        check_regs("midrst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        check("midrst.strobes", strobe_cnt - strobe_base, 32'd0);
        check("midrst.errors", err_cnt - err_base, 32'd0);

        spi_frame(32'h80AA, 16); wait_clk(10);
        check_regs("after_rst", 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00);
        check("after_rst.strobes", strobe_cnt - strobe_base, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
